// File: rtl/freq_counter_multi.sv
// rtl/freq_counter_multi.sv - multi-channel gated rising-edge frequency counter
//
// Counts rising edges on NUM_CH asynchronous inputs over a window of
// gate_cycles clk periods and publishes saturated per-channel results.
// Single-shot or continuous measurement; continuous mode has no dead time.
//
// Ports:
//   clk          system clock
//   resetn       synchronous reset, active low
//   in_signal    asynchronous inputs under measurement, one bit per channel
//   gate_cycles  window length in clk cycles (0 behaves as 1), sampled at window start
//   mode         0 = single-shot, 1 = continuous, sampled at window end
//   start        level, begins a measurement when seen in IDLE
//   stop         aborts a measurement; wins over start in IDLE
//   busy         high while a window is open
//   freq         channel i result in [(i+1)*CNT_W-1 : i*CNT_W]
//   overflow     per-channel saturation flag for the published window
//   freq_valid   one-cycle pulse when freq/overflow were updated

module freq_counter_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int GATE_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_CH-1:0]        in_signal,
  input  logic [GATE_W-1:0]        gate_cycles,
  input  logic                     mode,
  input  logic                     start,
  input  logic                     stop,
  output logic                     busy,
  output logic [NUM_CH*CNT_W-1:0]  freq,
  output logic [NUM_CH-1:0]        overflow,
  output logic                     freq_valid
);

  typedef enum logic {IDLE = 1'b0, GATE = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t              state;
  logic [GATE_W-1:0]   gate_cnt;
  logic [GATE_W-1:0]   gate_load;

  logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
  logic [NUM_CH-1:0]      sync_out;
  logic [NUM_CH-1:0]      hist_q;
  logic [NUM_CH-1:0]      edge_det;

  logic [CNT_W-1:0]    cnt_q   [NUM_CH];
  logic [CNT_W-1:0]    cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0]   ovf_q;
  logic [NUM_CH-1:0]   ovf_nxt;

  assign busy      = (state == GATE);
  assign gate_load = (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;

  // Synchroniser chain plus history flop; history runs in every state so an
  // edge that happened before the window opens is never seen as a new one.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        sync_q[ch] <= '0;
      end
      hist_q <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], in_signal[ch]};
      end
      hist_q <= sync_out;
    end
  end

  // Saturating next count; overflow means an edge arrived while already full,
  // so a window with exactly CNT_MAX edges is not flagged.
  always_comb begin
    sync_out = '0;
    edge_det = '0;
    ovf_nxt  = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      sync_out[ch] = sync_q[ch][SYNC_STAGES-1];
      edge_det[ch] = sync_out[ch] & ~hist_q[ch];
      cnt_nxt[ch]  = (cnt_q[ch] == CNT_MAX) ? CNT_MAX
                   : cnt_q[ch] + {{(CNT_W-1){1'b0}}, edge_det[ch]};
      ovf_nxt[ch]  = ovf_q[ch] | ((cnt_q[ch] == CNT_MAX) & edge_det[ch]);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      gate_cnt   <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cnt_q[ch] <= '0;
      end
      ovf_q      <= '0;
      freq       <= '0;
      overflow   <= '0;
      freq_valid <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!stop && start) begin
            state    <= GATE;
            gate_cnt <= gate_load;
            for (int ch = 0; ch < NUM_CH; ch++) begin
              cnt_q[ch] <= '0;
            end
            ovf_q    <= '0;
          end
        end
        GATE: begin
          if (stop) begin
            state <= IDLE;
          end else if (gate_cnt == GATE_W'(1)) begin
            // Final cycle: this cycle's edge goes into the published result,
            // and the counters restart from zero for a back-to-back window.
            for (int ch = 0; ch < NUM_CH; ch++) begin
              freq[ch*CNT_W +: CNT_W] <= cnt_nxt[ch];
              cnt_q[ch]               <= '0;
            end
            overflow   <= ovf_nxt;
            ovf_q      <= '0;
            freq_valid <= 1'b1;
            if (mode) begin
              gate_cnt <= gate_load;
            end else begin
              state <= IDLE;
            end
          end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
              cnt_q[ch] <= cnt_nxt[ch];
            end
            ovf_q    <= ovf_nxt;
            gate_cnt <= gate_cnt - GATE_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_counter_multi.sv
// tb/tb_freq_counter_multi.sv - scoreboard bench for freq_counter_multi

module tb_freq_counter_multi;

  typedef struct {
    int           cyc;
    logic [127:0] f;
    logic [3:0]   o;
  } exp_t;

  logic         clk = 1'b0;
  logic         resetn;
  logic [3:0]   in_signal;
  logic [31:0]  gate_cycles;
  logic         mode;
  logic         start_a;
  logic         start_b;
  logic         stop;

  logic         busy_a;
  logic [127:0] freq_a;
  logic [3:0]   ovf_a;
  logic         fv_a;

  logic         busy_b;
  logic [15:0]  freq_b;
  logic [3:0]   ovf_b;
  logic         fv_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a;
  exp_t e_b;

  int gen_base [4];
  int gen_per  [4];
  int gen_num  [4];
  logic [3:0] gen_sig;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pattern generator: channel i produces gen_num[i] pulses of period
  // gen_per[i] (high for per/2 cycles), the first rising just after posedge
  // number gen_base[i].
  always_comb begin
    gen_sig = '0;
    for (int i = 0; i < 4; i++) begin
      gen_sig[i] = (gen_num[i] > 0) && (cyc >= gen_base[i]) &&
                   ((cyc - gen_base[i]) / gen_per[i] < gen_num[i]) &&
                   ((cyc - gen_base[i]) % gen_per[i] < gen_per[i] / 2);
    end
  end
  assign in_signal = gen_sig;

  freq_counter_multi #(.NUM_CH(4), .CNT_W(32), .GATE_W(32), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .resetn(resetn), .in_signal(in_signal), .gate_cycles(gate_cycles),
    .mode(mode), .start(start_a), .stop(stop), .busy(busy_a), .freq(freq_a),
    .overflow(ovf_a), .freq_valid(fv_a)
  );

  freq_counter_multi #(.NUM_CH(4), .CNT_W(4), .GATE_W(32), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .resetn(resetn), .in_signal(in_signal), .gate_cycles(gate_cycles),
    .mode(mode), .start(start_b), .stop(stop), .busy(busy_b), .freq(freq_b),
    .overflow(ovf_b), .freq_valid(fv_b)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic gen_off();
    for (int i = 0; i < 4; i++) begin
      gen_num[i]  = 0;
      gen_per[i]  = 1;
      gen_base[i] = 0;
    end
  endtask

  task automatic set_gen(input int ch, input int base, input int per, input int num);
    gen_base[ch] = base;
    gen_per[ch]  = per;
    gen_num[ch]  = num;
  endtask

  task automatic push_a(input int c, input logic [127:0] f, input logic [3:0] o);
    exp_t e;
    e.cyc = c; e.f = f; e.o = o;
    q_a.push_back(e);
  endtask

  task automatic push_b(input int c, input logic [127:0] f, input logic [3:0] o);
    exp_t e;
    e.cyc = c; e.f = f; e.o = o;
    q_b.push_back(e);
  endtask

  // Called at a negedge; the start level is seen by the posedge that follows.
  task automatic pulse_start(input bit use_b);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  always @(negedge clk) begin
    if (fv_a === 1'b1) begin
      if (q_a.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL a_unexpected_valid: got freq_valid at cycle %0d expected none", cyc);
      end else begin
        e_a = q_a.pop_front();
        chk("a_freq", freq_a, e_a.f);
        chk("a_overflow", {124'd0, ovf_a}, {124'd0, e_a.o});
        chk("a_valid_cycle", 128'(cyc), 128'(e_a.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (fv_b === 1'b1) begin
      if (q_b.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL b_unexpected_valid: got freq_valid at cycle %0d expected none", cyc);
      end else begin
        e_b = q_b.pop_front();
        chk("b_freq", {112'd0, freq_b}, e_b.f);
        chk("b_overflow", {124'd0, ovf_b}, {124'd0, e_b.o});
        chk("b_valid_cycle", 128'(cyc), 128'(e_b.cyc));
      end
    end
  end

  initial begin
    int s;
    resetn      = 1'b0;
    gate_cycles = 32'd0;
    mode        = 1'b0;
    start_a     = 1'b0;
    start_b     = 1'b0;
    stop        = 1'b0;
    gen_off();

    // Reset state
    tick(3);
    chk("reset_busy", {127'd0, busy_a}, 128'd0);
    chk("reset_freq", freq_a, 128'd0);
    chk("reset_overflow", {124'd0, ovf_a}, 128'd0);
    chk("reset_valid", {127'd0, fv_a}, 128'd0);
    resetn = 1'b1;
    tick(4);

    // Single-shot, 100-cycle window: expect {20,0,25,10}
    s = cyc + 1;
    set_gen(0, s, 10, 10);
    set_gen(1, s, 4, 25);
    set_gen(3, s, 5, 20);
    gate_cycles = 32'd100;
    mode        = 1'b0;
    push_a(s + 100, {32'd20, 32'd0, 32'd25, 32'd10}, 4'b0000);
    pulse_start(1'b0);
    chk("single_busy_in_gate", {127'd0, busy_a}, 128'd1);
    tick(105);
    chk("single_busy_after", {127'd0, busy_a}, 128'd0);
    gen_off();
    tick(6);

    // Reset in the middle of a window discards it
    s = cyc + 1;
    set_gen(0, s, 10, 10);
    gate_cycles = 32'd100;
    pulse_start(1'b0);
    tick(20);
    resetn = 1'b0;
    tick(2);
    chk("midreset_busy", {127'd0, busy_a}, 128'd0);
    chk("midreset_freq", freq_a, 128'd0);
    chk("midreset_overflow", {124'd0, ovf_a}, 128'd0);
    chk("midreset_valid", {127'd0, fv_a}, 128'd0);
    resetn = 1'b1;
    tick(3);
    chk("midreset_idle", {127'd0, busy_a}, 128'd0);
    tick(100);
    gen_off();
    tick(6);

    // Continuous, four 50-cycle windows, ch0 period 5: 10 edges each, 40 total
    s = cyc + 1;
    set_gen(0, s, 5, 40);
    gate_cycles = 32'd50;
    mode        = 1'b1;
    for (int w = 1; w <= 4; w++) push_a(s + 50 * w, 128'd10, 4'b0000);
    pulse_start(1'b0);
    tick(175);
    mode = 1'b0;
    tick(35);
    chk("cont_busy_after", {127'd0, busy_a}, 128'd0);
    gen_off();
    tick(6);

    // Abort at cycle 30 of a 100-cycle window: no valid, previous result held
    gate_cycles = 32'd100;
    pulse_start(1'b0);
    tick(29);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("abort_busy", {127'd0, busy_a}, 128'd0);
    chk("abort_freq_held", freq_a, 128'd10);
    chk("abort_ovf_held", {124'd0, ovf_a}, 128'd0);
    start_a = 1'b1;
    stop    = 1'b1;
    tick(1);
    chk("start_stop_idle_1", {127'd0, busy_a}, 128'd0);
    tick(1);
    chk("start_stop_idle_2", {127'd0, busy_a}, 128'd0);
    start_a = 1'b0;
    stop    = 1'b0;
    tick(4);

    // gate_cycles = 0 behaves as a 1-cycle window
    s = cyc + 1;
    gate_cycles = 32'd0;
    mode        = 1'b0;
    push_a(s + 1, 128'd0, 4'b0000);
    pulse_start(1'b0);
    tick(5);
    chk("gate0_busy_after", {127'd0, busy_a}, 128'd0);

    // Edge counted on final cycle of window 1 (ch2) and on first of window 2 (ch1)
    s = cyc + 1;
    set_gen(2, s + 17, 4, 1);
    set_gen(1, s + 18, 4, 1);
    gate_cycles = 32'd20;
    mode        = 1'b1;
    push_a(s + 20, {32'd0, 32'd1, 32'd0, 32'd0}, 4'b0000);
    push_a(s + 40, {32'd0, 32'd0, 32'd1, 32'd0}, 4'b0000);
    pulse_start(1'b0);
    tick(30);
    mode = 1'b0;
    tick(15);
    gen_off();
    tick(4);

    // 4-bit build: 30 edges saturate at 15 with overflow, then 5 edges clean
    s = cyc + 1;
    set_gen(0, s, 4, 30);
    gate_cycles = 32'd130;
    mode        = 1'b1;
    push_b(s + 130, 128'd15, 4'b0001);
    push_b(s + 260, 128'd5, 4'b0000);
    pulse_start(1'b1);
    tick(125);
    set_gen(0, s + 140, 4, 5);
    tick(75);
    mode = 1'b0;
    tick(70);
    chk("sat_busy_after", {127'd0, busy_b}, 128'd0);
    gen_off();
    tick(4);

    chk("a_queue_drained", 128'(q_a.size()), 128'd0);
    chk("b_queue_drained", 128'(q_b.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
